// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind valid/ready request and response channels.
// Each access waits a fixed number of cycles before its response is offered.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  LAST_CNT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               commit;
    logic               handshake;
    logic [3:0]         cnt;

    logic               lat_we;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_wstrb;

    logic               acc_we;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [3:0]         acc_wstrb;
    logic               acc_err;
    logic [IDX_W-1:0]   acc_idx;

    logic [31:0]        mem [DEPTH_WORDS];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign handshake = (state == RESP) && rsp_ready;

    // With no wait states the commit edge is the acceptance edge, so the
    // request inputs are used directly instead of the not-yet-latched copy.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_wstrb = lat_wstrb;
        if (NO_WAIT && (state == IDLE)) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end
    end

    always_comb begin
        acc_err = (acc_addr[1:0] != 2'b00)
               || (acc_addr < BASE_ADDR)
               || ({1'b0, acc_addr} >= END_ADDR);
        acc_idx = IDX_W'((acc_addr - BASE_ADDR) >> 2);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (NO_WAIT) begin
                        next_state = RESP;
                        commit     = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == LAST_CNT) begin
                    next_state = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_wstrb <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if ((state == IDLE) && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
                cnt       <= 4'd0;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end

            if (commit) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
            end else if (handshake) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

    // The array has no reset; gating on resetn keeps a commit from landing
    // while reset is held, since the store must be discarded in that case.
    always_ff @(posedge clk) begin
        if (commit && resetn && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: one instance with two wait states,
// one with none, both checked against a simple word-array memory model.
module tb_data_mem_responder;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid_a;
   logic        req_valid_b;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_ready;

   logic        req_ready_a, rsp_valid_a, rsp_err_a;
   logic [31:0] rsp_rdata_a;
   logic        req_ready_b, rsp_valid_b, rsp_err_b;
   logic [31:0] rsp_rdata_b;

   bit          sel;
   logic        obs_req_ready, obs_rsp_valid, obs_rsp_err;
   logic [31:0] obs_rsp_rdata;

   int checks = 0;
   int errors = 0;

   bit [31:0] model_mem   [2][DEPTH];
   bit        model_known [2][DEPTH];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
   );

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
   );

   assign obs_req_ready = sel ? req_ready_b : req_ready_a;
   assign obs_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
   assign obs_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
   assign obs_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;

   // Compare one observed value against the bench's own expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // An access is in range when it is word aligned and inside the window.
   function automatic bit modelErr(input logic [31:0] addr);
      longint a = longint'(addr);
      return (a % 4 != 0) || (a < longint'(BASE)) || (a >= longint'(BASE) + DEPTH * 4);
   endfunction

   // Run one complete access on the selected instance, holding the response
   // for 'hold' extra cycles while a stray request is presented.
   task automatic applyStimulus(input bit s, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input int hold, output logic [31:0] rdata, output logic err);
      bit          exp_err;
      int          idx;
      logic [31:0] exp_rdata;
      int          k;
      exp_err   = modelErr(addr);
      idx       = exp_err ? 0 : int'((addr - BASE) >> 2);
      exp_rdata = (!we && !exp_err) ? model_mem[s][idx] : 32'd0;

      @(negedge clk);
      sel         = s;
      req_valid_a = !s;
      req_valid_b = s;
      req_we      = we;
      req_addr    = addr;
      req_wdata   = wdata;
      req_wstrb   = wstrb;
      rsp_ready   = 1'b0;
      #1 checkOutput("req_ready_before_accept", 32'(obs_req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      req_we      = 1'($urandom);
      req_addr    = $urandom;
      req_wdata   = $urandom;
      req_wstrb   = 4'($urandom);
      checkOutput("req_ready_after_accept", 32'(obs_req_ready), 32'd0);
      k = 0;
      while (!obs_rsp_valid && k < 50) begin
         @(posedge clk);
         #1 k++;
      end
      checkOutput("latency", 32'(k), s ? 32'd0 : 32'd2);
      checkOutput("rsp_err", 32'(obs_rsp_err), 32'(exp_err));
      checkOutput("rsp_rdata", obs_rsp_rdata, exp_rdata);
      rdata = obs_rsp_rdata;
      err   = obs_rsp_err;

      for (int i = 0; i < hold; i++) begin
         req_valid_a = !s;
         req_valid_b = s;
         req_we      = 1'b1;
         @(posedge clk);
         #1;
         checkOutput("hold_valid", 32'(obs_rsp_valid), 32'd1);
         checkOutput("hold_rdata", obs_rsp_rdata, exp_rdata);
         checkOutput("hold_err", 32'(obs_rsp_err), 32'(exp_err));
         checkOutput("hold_req_ready", 32'(obs_req_ready), 32'd0);
      end

      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      rsp_ready   = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checkOutput("post_rsp_valid", 32'(obs_rsp_valid), 32'd0);
      checkOutput("post_req_ready", 32'(obs_req_ready), 32'd1);
      checkOutput("post_rdata", obs_rsp_rdata, 32'd0);
      checkOutput("post_err", 32'(obs_rsp_err), 32'd0);

      if (we && !exp_err) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) model_mem[s][idx][8*b +: 8] = wdata[8*b +: 8];
         end
         if (wstrb == 4'hF) model_known[s][idx] = 1'b1;
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;

      resetn      = 1'b0;
      sel         = 1'b0;
      req_valid_a = 1'b1;
      req_valid_b = 1'b1;
      req_we      = 1'b0;
      req_addr    = 32'h10;
      req_wdata   = 32'd0;
      req_wstrb   = 4'hF;
      rsp_ready   = 1'b0;

      // Reset held with requests pending: nothing may be accepted.
      repeat (3) begin
         @(negedge clk);
         checkOutput("rst_req_ready_a", 32'(req_ready_a), 32'd1);
         checkOutput("rst_rsp_valid_a", 32'(rsp_valid_a), 32'd0);
         checkOutput("rst_rsp_valid_b", 32'(rsp_valid_b), 32'd0);
         checkOutput("rst_rdata_a", rsp_rdata_a, 32'd0);
         checkOutput("rst_err_a", 32'(rsp_err_a), 32'd0);
      end
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      resetn      = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("after_rst_req_ready_a", 32'(req_ready_a), 32'd1);
      checkOutput("after_rst_req_ready_b", 32'(req_ready_b), 32'd1);

      // Basic store then load.
      applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
      checkOutput("store_err", 32'(er), 32'd0);
      applyStimulus(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er);
      checkOutput("load_deadbeef", rd, 32'hDEADBEEF);

      // Byte strobes.
      applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er);
      applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er);
      applyStimulus(0, 1'b0, 32'h20, 32'd0, 4'h0, 0, rd, er);
      checkOutput("strobe_merge", rd, 32'h11BB33DD);

      // Misaligned and out-of-range accesses.
      applyStimulus(0, 1'b0, 32'h22, 32'd0, 4'h0, 0, rd, er);
      checkOutput("misaligned_err", 32'(er), 32'd1);
      checkOutput("misaligned_rdata", rd, 32'd0);
      applyStimulus(0, 1'b1, BASE, 32'h600D0000, 4'hF, 0, rd, er);
      applyStimulus(0, 1'b1, BASE + 32'd4096, 32'hBAD0BAD0, 4'hF, 0, rd, er);
      checkOutput("range_err", 32'(er), 32'd1);
      applyStimulus(0, 1'b0, BASE, 32'd0, 4'h0, 0, rd, er);
      checkOutput("index0_unchanged", rd, 32'h600D0000);

      // Empty strobe leaves memory alone.
      applyStimulus(0, 1'b1, 32'h10, 32'h01010101, 4'h0, 0, rd, er);
      applyStimulus(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er);
      checkOutput("zero_strobe", rd, 32'hDEADBEEF);

      // Back-pressure on the response.
      applyStimulus(0, 1'b0, 32'h20, 32'd0, 4'h0, 5, rd, er);

      // Reset during the wait states of a store discards it.
      applyStimulus(0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 0, rd, er);
      @(negedge clk);
      sel         = 1'b0;
      req_valid_a = 1'b1;
      req_we      = 1'b1;
      req_addr    = 32'h30;
      req_wdata   = 32'h12345678;
      req_wstrb   = 4'hF;
      @(posedge clk);
      #1;
      req_valid_a = 1'b0;
      checkOutput("midrst_in_wait", 32'(req_ready_a), 32'd0);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      checkOutput("midrst_req_ready", 32'(req_ready_a), 32'd1);
      checkOutput("midrst_rsp_valid", 32'(rsp_valid_a), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      applyStimulus(0, 1'b0, 32'h30, 32'd0, 4'h0, 0, rd, er);
      checkOutput("midrst_old_value", rd, 32'h0BADF00D);

      // Zero wait states.
      applyStimulus(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, rd, er);
      applyStimulus(1, 1'b0, 32'h10, 32'd0, 4'h0, 2, rd, er);
      checkOutput("nowait_load", rd, 32'hCAFEF00D);

      // Random traffic on both instances against the model.
      for (int n = 0; n < 60; n++) begin
         bit          s;
         int          kind;
         int          w;
         logic [31:0] a;
         logic [3:0]  st;
         s    = 1'($urandom_range(1));
         kind = $urandom_range(9);
         w    = $urandom_range(63);
         if (kind >= 4 && kind <= 7 && !model_known[s][w]) kind = 0;
         case (kind)
            0, 1, 2, 3: begin
               st = model_known[s][w] ? 4'($urandom) : 4'hF;
               applyStimulus(s, 1'b1, BASE + 32'(w * 4), $urandom, st, $urandom_range(3), rd, er);
            end
            4, 5, 6, 7: begin
               applyStimulus(s, 1'b0, BASE + 32'(w * 4), 32'd0, 4'h0, $urandom_range(3), rd, er);
            end
            8: begin
               a = BASE + 32'(w * 4) + 32'($urandom_range(1, 3));
               applyStimulus(s, 1'($urandom), a, $urandom, 4'hF, $urandom_range(3), rd, er);
            end
            default: begin
               a = ($urandom_range(1) == 1) ? 32'hFFFF_FFFC : BASE + 32'd4096 + 32'($urandom_range(1000) * 4);
               applyStimulus(s, 1'($urandom), a, $urandom, 4'hF, $urandom_range(3), rd, er);
            end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data memory that serves load/store requests from `singleCycleCPU` or a bench-side initiator over a valid/ready request channel and a valid/ready response channel. It models a slow memory: a fixed, parameterised number of wait states is inserted between accepting a request and returning its response. Misaligned or out-of-range accesses are reported through an error flag. It runs on the CPU clock and sits outside the core.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, at least 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_CYCLES`, 2: wait states between acceptance and response; range 0..15.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request can be accepted this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_wstrb`  in  4  byte-lane enables for stores; bit i covers bits [8i+7:8i]. Ignored on loads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator takes the response.
- `rsp_rdata`  out  32  load data; 0 for stores and on errors.
- `rsp_err`  out  1  access was misaligned or out of range.

## Operation
- The FSM has three states: IDLE, WAIT and RESP. `req_ready` = (state == IDLE). `rsp_valid` = (state == RESP).
- **IDLE:** on `req_valid && req_ready`, latch we/addr/wdata/wstrb. After the latch, the request inputs are don't-care.
  - Go to WAIT with the counter at 0 if `WAIT_CYCLES > 0`.
  - Go directly to RESP if `WAIT_CYCLES == 0`.
- **WAIT:** the counter increments each cycle. When counter == `WAIT_CYCLES-1`, go to RESP.
- **Entry into RESP (the commit edge):**
  - Error check: `err = (addr[1:0] != 0) || (addr < BASE_ADDR) || (addr >= BASE_ADDR + DEPTH_WORDS*4)`.
  - Index: `idx = (addr - BASE_ADDR) >> 2`, width log2(`DEPTH_WORDS`).
  - Store, no error: write the strobed bytes of `mem[idx]`; leave the other bytes unchanged; `rsp_rdata` = 0.
  - Load, no error: `rsp_rdata` = `mem[idx]`, the value before this edge.
  - Error: no memory write; `rsp_rdata` = 0; `rsp_err` = 1.
- **RESP:** hold `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready` is sampled high. Then go to IDLE and clear `rsp_err` and `rsp_rdata` to 0.
- Store with `req_wstrb == 4'b0000`: completes normally; memory is unchanged.
- Memory array: no reset; contents are preserved across `resetn`. The bench initialises it through the store path or a hierarchical `$readmemh`.

## Timing
- Reset values, while `resetn` is low and immediately after: state IDLE, `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, counter = 0.
- Latency: a request accepted at edge E0 has `rsp_valid` high from just after edge E0+`WAIT_CYCLES` (`WAIT_CYCLES`+1 cycles after the acceptance cycle).
- Throughput: one request in flight at most. The response handshake at edge E1 returns the block to IDLE; the next acceptance happens at E1+1 at the earliest. Peak rate is one access per `WAIT_CYCLES`+2 cycles.
- `req_ready` is low from the acceptance edge until the response-handshake edge. `req_valid` during that time has no effect.
- `rsp_ready` outside RESP: ignored.
- Store visibility: a store committed at its RESP entry is visible to every later load, including the very next request.
- Reset mid-operation: asserting `resetn` asynchronously forces the reset values.
  - A store still in WAIT is discarded; memory is untouched.
  - A store already in RESP has already been written.

## Test plan
- **Reset:** hold `resetn`=0 for 3 cycles with `req_valid`=1 -> `req_ready`=1, `rsp_valid`=0, no acceptance until `resetn` rises.
- **Store/load, `WAIT_CYCLES`=2:** store 32'hDEADBEEF to 0x10 with wstrb 4'hF; `rsp_ready` tied high -> `rsp_valid` high 3 cycles after acceptance, `rsp_err`=0. Then load 0x10 -> `rsp_rdata`=32'hDEADBEEF.
- **Byte strobes:** memory word at 0x20 = 32'h11223344; store 32'hAABBCCDD with wstrb 4'b0101 -> a load of 0x20 returns 32'h11BB33DD.
- **Errors:** load from 0x22 -> `rsp_err`=1, `rsp_rdata`=0. Store to `BASE_ADDR`+4096 with `DEPTH_WORDS`=1024 -> `rsp_err`=1; a load of index 0 is unchanged.
- **Back-pressure:** hold `rsp_ready`=0 for 5 cycles in RESP -> `rsp_valid`/`rsp_rdata` stable, `req_ready`=0, a second `req_valid` is ignored. Raise `rsp_ready` -> IDLE, `req_ready`=1 in the following cycle.
- **Mid-operation reset and `WAIT_CYCLES`=0:** pulse `resetn` low during WAIT of a store to 0x30 -> a later load of 0x30 returns the old value. With `WAIT_CYCLES`=0, `rsp_valid` is high in the cycle after acceptance.
